// File: rtl/fft_sample_loader.sv
// fft_sample_loader
//   Input stage of the eight-point FFT datapath. Complex samples arrive one
//   per cycle on a valid/ready stream. They are assembled into 8-sample frames
//   in two ping-pong banks: one bank fills while the other is presented, in
//   parallel, to the downstream butterfly stage.
//
//   Build option:
//     FFT_BITREV_EN  When defined, sample k is stored in slot bitrev3(k), so
//                    the frame reaches the butterflies already in
//                    decimation-in-time order. When undefined, samples are
//                    stored in natural order and a reorder stage is needed
//                    downstream.
//
//   Ports:
//     clk          clock; all state changes on the rising edge
//     rst          synchronous, active-high reset
//     in_valid     in_data holds a sample
//     in_data      input sample: real part in [15:8], imaginary part in [7:0]
//     in_ready     loader can accept a sample this cycle
//     frame_valid  frame_data holds a complete frame
//     frame_ready  downstream accepts the frame this cycle
//     frame_data   complete frame; slot i is at [i*W +: W]
//     frame_cnt    frames handed over since reset; wraps from 255 to 0
module fft_sample_loader #(
    parameter int W       = 16,
    parameter int PTS     = 8,
    parameter int LOG2PTS = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [W-1:0]     in_data,
    output logic             in_ready,
    output logic             frame_valid,
    input  logic             frame_ready,
    output logic [PTS*W-1:0] frame_data,
    output logic [7:0]       frame_cnt
);

    // Two banks of PTS samples each, indexed [bank][slot].
    logic [1:0][PTS-1:0][W-1:0] bank_q, bank_d;
    logic [1:0]                 full_q, full_d;
    logic                       wr_bank_q, wr_bank_d;
    logic [LOG2PTS-1:0]         wr_idx_q, wr_idx_d;
    logic                       rd_bank_q, rd_bank_d;
    logic [7:0]                 frame_cnt_q, frame_cnt_d;

    logic in_accept;
    logic frame_accept;

    // Maps the arrival index of a sample to its storage slot.
    function automatic logic [LOG2PTS-1:0] slot(input logic [LOG2PTS-1:0] k);
        logic [LOG2PTS-1:0] r;
`ifdef FFT_BITREV_EN
        for (int i = 0; i < LOG2PTS; i++) begin
            r[i] = k[LOG2PTS-1-i];
        end
`else
        r = k;
`endif
        return r;
    endfunction

    // Every output comes from registers only. in_ready does not depend on
    // frame_ready, so a bank freed at this edge becomes writable next cycle.
    assign in_ready     = ~full_q[wr_bank_q];
    assign frame_valid  = full_q[rd_bank_q];
    assign frame_data   = bank_q[rd_bank_q];
    assign frame_cnt    = frame_cnt_q;

    assign in_accept    = in_valid & in_ready;
    assign frame_accept = frame_valid & frame_ready;

    always_comb begin
        // NOTE: every _d first takes its _q value, so no path through this block leaves a signal unassigned and no latch is inferred.
        bank_d      = bank_q;
        full_d      = full_q;
        wr_bank_d   = wr_bank_q;
        wr_idx_d    = wr_idx_q;
        rd_bank_d   = rd_bank_q;
        frame_cnt_d = frame_cnt_q;

        // A frame accept and a write always target different banks: a write
        // needs its bank empty and an accept needs its bank full. Both can
        // therefore take effect on the same edge.
        if (frame_accept) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
            frame_cnt_d       = frame_cnt_q + 8'd1;
        end

        if (in_accept) begin
            bank_d[wr_bank_q][slot(wr_idx_q)] = in_data;
            wr_idx_d = wr_idx_q + 1'b1;   // wraps to 0 after the last slot
            if (wr_idx_q == LOG2PTS'(PTS - 1)) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the sample storage is reset too. frame_data then reads 0 after reset, and a discarded partial frame leaves nothing behind.
            bank_q      <= '0;
            full_q      <= '0;
            wr_bank_q   <= 1'b0;
            wr_idx_q    <= '0;
            rd_bank_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments make every flop update from its pre-edge value, whatever the order of the statements.
            bank_q      <= bank_d;
            full_q      <= full_d;
            wr_bank_q   <= wr_bank_d;
            wr_idx_q    <= wr_idx_d;
            rd_bank_q   <= rd_bank_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

endmodule

// File: tb/tb_fft_sample_loader.sv
// Testbench for fft_sample_loader.
//   Holds a scoreboard queue of expected frames. A frame is pushed when the
//   bench drives the eighth accepted sample, and popped when the loader hands
//   the frame over. On every cycle the bench checks in_ready, frame_valid,
//   frame_cnt and the head frame against its own model. Directed sequences
//   cover reset, a single frame, backpressure, a simultaneous fill and accept,
//   and reset during a fill. A short random phase follows.
module tb_fft_sample_loader;

    localparam int W   = 16;
    localparam int PTS = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [W-1:0]     in_data;
    logic             in_ready;
    logic             frame_valid;
    logic             frame_ready;
    logic [PTS*W-1:0] frame_data;
    logic [7:0]       frame_cnt;

    always #5 clk = ~clk;

    fft_sample_loader #(.W(W), .PTS(PTS), .LOG2PTS(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .frame_data  (frame_data),
        .frame_cnt   (frame_cnt)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state.
    logic [PTS*W-1:0] sb[$];
    logic [PTS*W-1:0] fill;
    int               fill_idx;
    logic [7:0]       exp_cnt;
    bit               model_ok = 1'b0;
    bit               last_acc;
    logic [W-1:0]     next_data;

    function automatic int slot_of(input int k);
`ifdef FFT_BITREV_EN
        return ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
`else
        return k;
`endif
    endfunction

    task automatic check(input string tag, input logic [PTS*W-1:0] got,
                         input logic [PTS*W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Runs one clock cycle. Outputs are checked at the falling edge. The
    // model is updated at the rising edge. The task returns 1 time unit
    // after the rising edge, so the caller can change the inputs.
    task automatic cycle();
        bit acc_in;
        bit acc_fr;
        bit exp_rdy;
        @(negedge clk);
        exp_rdy = (sb.size() < 2);
        if (model_ok) begin
            check("in_ready", in_ready, exp_rdy);
            check("frame_valid", frame_valid, sb.size() > 0);
            check("frame_cnt", frame_cnt, exp_cnt);
            if (sb.size() > 0) check("frame_data", frame_data, sb[0]);
        end
        acc_in = !rst && in_valid && exp_rdy;
        acc_fr = !rst && frame_ready && (sb.size() > 0);
        @(posedge clk);
        if (rst) begin
            sb.delete();
            fill_idx = 0;
            exp_cnt  = '0;
            model_ok = 1'b1;
        end else begin
            if (acc_fr) begin
                sb.delete(0);
                exp_cnt++;
            end
            if (acc_in) begin
                fill[slot_of(fill_idx)*W +: W] = in_data;
                fill_idx++;
                if (fill_idx == PTS) begin
                    sb.push_back(fill);
                    fill_idx = 0;
                end
            end
        end
        last_acc = acc_in;
        #1;
    endtask

    // Streams n samples with consecutive values starting at next_data. The
    // current value is held until it is accepted. The task stops after
    // budget cycles and returns the number of samples accepted.
    task automatic send(input int n, input int budget, output int sent);
        sent = 0;
        for (int c = 0; c < budget && sent < n; c++) begin
            in_valid = 1'b1;
            in_data  = next_data;
            cycle();
            if (last_acc) begin
                sent++;
                next_data++;
            end
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sent;
        logic [W-1:0] base;

        rst         = 1'b1;
        in_valid    = 1'b0;
        in_data     = '0;
        frame_ready = 1'b0;
        next_data   = 16'h0100;
        fill        = '0;
        fill_idx    = 0;
        exp_cnt     = '0;

        // Reset for two cycles.
        repeat (2) cycle();
        rst = 1'b0;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_frame_valid", frame_valid, 1'b0);
        check("rst_frame_data", frame_data, '0);
        check("rst_frame_cnt", frame_cnt, 8'd0);

        // Single frame, samples 0100..0107 back-to-back.
        frame_ready = 1'b1;
        send(8, 20, sent);
        check("t2_sent", sent, 8);
        check("t2_valid", frame_valid, 1'b1);
`ifdef FFT_BITREV_EN
        check("t2_slot1", frame_data[1*W +: W], 16'h0104);
        check("t2_slot3", frame_data[3*W +: W], 16'h0106);
        check("t2_slot6", frame_data[6*W +: W], 16'h0103);
`else
        for (int i = 0; i < PTS; i++) begin
            check($sformatf("t2_slot%0d", i), frame_data[i*W +: W], 16'h0100 + i);
        end
`endif
        cycle();
        check("t2_cnt", frame_cnt, 8'd1);
        check("t2_valid_after", frame_valid, 1'b0);

        // Backpressure: with frame_ready low, both banks fill and the input stalls.
        frame_ready = 1'b0;
        base = next_data;
        send(20, 24, sent);
        check("t4_sent", sent, 16);
        check("t4_in_ready", in_ready, 1'b0);
        check("t4_f0_slot0", frame_data[0 +: W], base);
        check("t4_f0_slot7", frame_data[7*W +: W], base + 16'd7);
        in_valid    = 1'b1;
        in_data     = next_data;
        frame_ready = 1'b1;
        cycle();
        check("t4_stall_acc", last_acc, 1'b0);
        frame_ready = 1'b0;
        check("t4_f1_valid", frame_valid, 1'b1);
        check("t4_f1_slot0", frame_data[0 +: W], base + 16'd8);
        check("t4_ready_after", in_ready, 1'b1);
        send(8, 12, sent);
        check("t4_sent_rest", sent, 8);
        frame_ready = 1'b1;
        repeat (4) cycle();
        check("t4_drained", frame_valid, 1'b0);
        check("t4_cnt", frame_cnt, 8'd4);

        // The 8th sample of bank1 and the accept of bank0 fall on the same edge.
        frame_ready = 1'b0;
        base = next_data;
        send(8, 10, sent);
        send(7, 10, sent);
        check("t5_ready_mid", in_ready, 1'b1);
        in_valid    = 1'b1;
        in_data     = next_data;
        frame_ready = 1'b1;
        cycle();
        if (last_acc) next_data++;
        in_valid    = 1'b0;
        frame_ready = 1'b0;
        check("t5_valid", frame_valid, 1'b1);
        check("t5_cnt", frame_cnt, 8'd5);
        check("t5_in_ready", in_ready, 1'b1);
        check("t5_slot0", frame_data[0 +: W], base + 16'd8);
        frame_ready = 1'b1;
        repeat (2) cycle();
        check("t5_cnt_after", frame_cnt, 8'd6);

        // Reset during a fill discards the partial frame.
        send(5, 10, sent);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("t6_in_ready", in_ready, 1'b1);
        check("t6_valid", frame_valid, 1'b0);
        check("t6_cnt", frame_cnt, 8'd0);
        check("t6_data", frame_data, '0);
        next_data = 16'h0200;
        send(8, 12, sent);
        check("t6_sent", sent, 8);
        for (int k = 0; k < PTS; k++) begin
            check($sformatf("t6_k%0d", k), frame_data[slot_of(k)*W +: W], 16'h0200 + k);
        end
        cycle();
        check("t6_cnt_after", frame_cnt, 8'd1);

        // Random valid/ready traffic; the per-cycle checks track the model.
        for (int c = 0; c < 300; c++) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            in_data     = next_data;
            frame_ready = ($urandom_range(0, 2) == 0);
            cycle();
            if (last_acc) next_data++;
        end
        in_valid    = 1'b0;
        frame_ready = 1'b1;
        repeat (4) cycle();
        check("rand_drained", frame_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
